// File: rtl/fib_pkg.sv
// Shared widths, depth and term type for the Fibonacci stream path.
package fib_pkg;

  localparam int FIB_DATA_W    = 16;
  localparam int FIB_BUF_DEPTH = 8;

  typedef logic [FIB_DATA_W-1:0] fib_term_t;

  // Occupancy needs one extra bit so that "full" (== depth) is representable.
  function automatic int fib_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fib_fifo_mem.sv
// DEPTH x DATA_W storage: one synchronous write port, asynchronous read port.
// No backpressure here; the caller decides when we is safe to assert.
module fib_fifo_mem
  import fib_pkg::*;
#(
  parameter int DATA_W = FIB_DATA_W,
  parameter int DEPTH  = FIB_BUF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage is not reset; validity is tracked by the occupancy count.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fib_stream_buffer.sv
// FWFT buffer for generator terms: write-to-out_valid latency 1 cycle; gen_en drops at AFULL_LVL,
// overflow inputs are dropped with a pulse. FIB_BUF_STATS_EN adds the saturating acc_cnt port.
module fib_stream_buffer
  import fib_pkg::*;
#(
  parameter int DATA_W    = FIB_DATA_W,
  parameter int DEPTH     = FIB_BUF_DEPTH,
  parameter int AFULL_LVL = DEPTH - 2,
  localparam int AW       = $clog2(DEPTH),
  localparam int CW       = fib_cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              gen_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CW-1:0]     count,
  output logic              drop,
`ifdef FIB_BUF_STATS_EN
  output logic [15:0]       acc_cnt,
`endif
  output logic              wrap_seen
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              drop_q, drop_d;
  logic              wrap_q, wrap_d;
  logic              first_q, first_d;
  logic [DATA_W-1:0] last_q, last_d;
  logic              rd_raw, wr_raw, rd, wr;

  assign out_valid = (count_q != '0);
  assign rd_raw    = out_valid && out_ready;
  // A read in the same cycle frees a slot, so a full FIFO can still accept.
  assign wr_raw    = in_valid && ((count_q < DEPTH_C) || rd_raw);
  assign rd        = rd_raw && !clr;
  assign wr        = wr_raw && !clr;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = 1'b0;
    wrap_d   = wrap_q;
    first_d  = first_q;
    last_d   = last_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      wrap_d   = 1'b0;
      first_d  = 1'b1;
    end else begin
      drop_d = in_valid && !wr_raw;
      if (rd) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (wr) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        // Fibonacci terms never decrease, so a smaller term means 16-bit wrap.
        if (!first_q && (in_data < last_q)) begin
          wrap_d = 1'b1;
        end
        last_d  = in_data;
        first_d = 1'b0;
      end
      if (wr && !rd) begin
        count_d = count_q + CW'(1);
      end else if (rd && !wr) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= 1'b0;
      wrap_q   <= 1'b0;
      first_q  <= 1'b1;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
      wrap_q   <= wrap_d;
      first_q  <= first_d;
      last_q   <= last_d;
    end
  end

  fib_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_ptr_q),
    .rdata (out_data)
  );

  assign gen_en    = (count_q < AFULL_C) && !clr;
  assign count     = count_q;
  assign drop      = drop_q;
  assign wrap_seen = wrap_q;

`ifdef FIB_BUF_STATS_EN
  logic [15:0] acc_cnt_q, acc_cnt_d;

  always_comb begin
    acc_cnt_d = acc_cnt_q;
    if (clr) begin
      acc_cnt_d = '0;
    end else if (wr && (acc_cnt_q != 16'hFFFF)) begin
      acc_cnt_d = acc_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_cnt_q <= '0;
    end else begin
      acc_cnt_q <= acc_cnt_d;
    end
  end

  assign acc_cnt = acc_cnt_q;
`endif

endmodule
